// File: rtl/noc_local_inject_buffer.sv
// Local-port injection buffer: absorbs a registered-valid endpoint into a FWFT flit FIFO
// and re-drives it to the router. Define NOC_INJ_FRAME_CHECK_EN to build header/tail framing checks.
module noc_local_inject_buffer #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned Noc_Data_Width = 32
) (
  input  logic                        noc_clk,
  input  logic                        noc_rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [Noc_Data_Width-1:0]   in_flit,
  input  logic                        in_is_header,
  input  logic                        in_is_tail,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [Noc_Data_Width-1:0]   out_flit,
  output logic                        out_is_header,
  output logic                        out_is_tail,
  output logic [$clog2(DEPTH):0]      occupancy,
  output logic [15:0]                 pkt_count,
  output logic [1:0]                  err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = PW + 1;
  localparam int unsigned EW = Noc_Data_Width + 2;

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [OW-1:0] occ_q;
  logic [OW-1:0] occ_next;
  logic          full;
  logic          rd_en;
  logic          wr_en;
  logic          frame_ok;
  logic          frame_err;
  logic          ovf;

  assign head          = mem[rd_ptr];
  assign out_valid     = (occ_q != '0);
  assign out_flit      = head[Noc_Data_Width-1:0];
  assign out_is_header = head[Noc_Data_Width];
  assign out_is_tail   = head[Noc_Data_Width+1];
  assign occupancy     = occ_q;

  assign full  = (occ_q == OW'(DEPTH));
  assign rd_en = out_valid && out_ready;
  // A full FIFO still takes a flit when the head leaves in the same cycle.
  assign wr_en = in_valid && frame_ok && (!full || rd_en);
  assign ovf   = in_valid && full && !rd_en;

`ifdef NOC_INJ_FRAME_CHECK_EN
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_IN_PKT = 1'b1;

  logic [0:0] state;
  logic [0:0] state_next;

  // IDLE accepts only headers; inside a packet headers are rejected.
  assign frame_ok  = (state == ST_IDLE) ? in_is_header : !in_is_header;
  assign frame_err = in_valid && !frame_ok;

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Framing state advances only on flits that are actually stored.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (wr_en && !in_is_tail) state_next = ST_IN_PKT;
      ST_IN_PKT: if (wr_en && in_is_tail)  state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end
`else
  assign frame_ok  = 1'b1;
  assign frame_err = 1'b0;
`endif

  always_comb begin
    occ_next = occ_q;
    case ({wr_en, rd_en})
      2'b10:   occ_next = occ_q + OW'(1);
      2'b01:   occ_next = occ_q - OW'(1);
      default: occ_next = occ_q;
    endcase
  end

  always_ff @(posedge noc_clk) begin
    if (wr_en) mem[wr_ptr] <= {in_is_tail, in_is_header, in_flit};
  end

  // in_ready leaves room for the flit already launched by the endpoint.
  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occ_q     <= '0;
      in_ready  <= 1'b0;
      pkt_count <= 16'd0;
      err       <= 2'b00;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      occ_q    <= occ_next;
      in_ready <= (occ_next <= OW'(DEPTH - 2));
      if (rd_en && out_is_tail) pkt_count <= pkt_count + 16'd1;
      err      <= err | {ovf, frame_err};
    end
  end

endmodule

// File: tb/tb_noc_local_inject_buffer.sv
// Directed bench for noc_local_inject_buffer (DEPTH=4): vector table plus hand-written
// reset, orphan and duplicate-header sequences; expectations follow NOC_INJ_FRAME_CHECK_EN.
module tb_noc_local_inject_buffer;

  logic        noc_clk = 1'b0;
  logic        noc_rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_flit = 32'd0;
  logic        in_is_header = 1'b0;
  logic        in_is_tail = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_flit;
  logic        out_is_header;
  logic        out_is_tail;
  logic [2:0]  occupancy;
  logic [15:0] pkt_count;
  logic [1:0]  err;

  int total = 0;
  int bad   = 0;

  noc_local_inject_buffer #(.DEPTH(4), .Noc_Data_Width(32)) dut (
    .noc_clk(noc_clk), .noc_rst(noc_rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
    .in_is_header(in_is_header), .in_is_tail(in_is_tail),
    .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit),
    .out_is_header(out_is_header), .out_is_tail(out_is_tail),
    .occupancy(occupancy), .pkt_count(pkt_count), .err(err)
  );

  always #5 noc_clk = ~noc_clk;

  typedef struct {
    logic        v, h, t;
    logic [31:0] f;
    logic        ordy;
    logic [2:0]  occ;
    logic [31:0] of;
    logic        oh, ot, irdy;
    logic [15:0] pkt;
    logic [1:0]  err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic h, logic t, logic [31:0] f, logic ordy,
                              logic [2:0] occ, logic [31:0] of, logic oh, logic ot,
                              logic irdy, logic [15:0] pkt, logic [1:0] e);
    vec_t r;
    r.v = v; r.h = h; r.t = t; r.f = f; r.ordy = ordy;
    r.occ = occ; r.of = of; r.oh = oh; r.ot = ot; r.irdy = irdy; r.pkt = pkt; r.err = e;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic h, input logic t, input logic [31:0] f,
                      input logic ordy);
    in_valid = v; in_is_header = h; in_is_tail = t; in_flit = f; out_ready = ordy;
    @(posedge noc_clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_occ"},       32'(occupancy), 32'd0);
    chk({tag, "_pkt"},       32'(pkt_count), 32'd0);
    chk({tag, "_err"},       32'(err),       32'd0);
  endtask

  initial begin
    logic [31:0] exp_q[$];
    logic [1:0]  e_fr;

    // Single packet: header + 11 data + tail, out_ready=1, each flit visible one cycle after entry.
    vecs.push_back(mk(1, 1, 0, 32'h100, 1, 3'd1, 32'h100, 1, 0, 1, 16'd0, 2'b00));
    for (int i = 1; i <= 11; i++)
      vecs.push_back(mk(1, 0, 0, 32'h100 + 32'(i), 1, 3'd1, 32'h100 + 32'(i), 0, 0, 1, 16'd0, 2'b00));
    vecs.push_back(mk(1, 0, 1, 32'h10C, 1, 3'd1, 32'h10C, 0, 1, 1, 16'd0, 2'b00));
    vecs.push_back(mk(0, 0, 0, 32'h0,   1, 3'd0, 32'h0,   0, 0, 1, 16'd1, 2'b00));
    // Backpressure: in_ready drops at occupancy 3, in-flight tail lands at 4.
    vecs.push_back(mk(1, 1, 0, 32'h200, 0, 3'd1, 32'h200, 1, 0, 1, 16'd1, 2'b00));
    vecs.push_back(mk(1, 0, 0, 32'h201, 0, 3'd2, 32'h200, 1, 0, 1, 16'd1, 2'b00));
    vecs.push_back(mk(1, 0, 0, 32'h202, 0, 3'd3, 32'h200, 1, 0, 0, 16'd1, 2'b00));
    vecs.push_back(mk(1, 0, 1, 32'h203, 0, 3'd4, 32'h200, 1, 0, 0, 16'd1, 2'b00));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 3'd4, 32'h200, 1, 0, 0, 16'd1, 2'b00));
    // Overflow: single-flit packet forced while full is dropped and flags err[1].
    vecs.push_back(mk(1, 1, 1, 32'h2FF, 0, 3'd4, 32'h200, 1, 0, 0, 16'd1, 2'b10));
    // Drain in order.
    vecs.push_back(mk(0, 0, 0, 32'h0, 1, 3'd3, 32'h201, 0, 0, 0, 16'd1, 2'b10));
    vecs.push_back(mk(0, 0, 0, 32'h0, 1, 3'd2, 32'h202, 0, 0, 1, 16'd1, 2'b10));
    vecs.push_back(mk(0, 0, 0, 32'h0, 1, 3'd1, 32'h203, 0, 1, 1, 16'd1, 2'b10));
    vecs.push_back(mk(0, 0, 0, 32'h0, 1, 3'd0, 32'h0,   0, 0, 1, 16'd2, 2'b10));

    // Reset state, then in_ready rises at the first edge after reset falls.
    @(posedge noc_clk); #1;
    chk_reset_vals("rst0");
    noc_rst = 1'b0;
    chk("rst_release_in_ready_low", 32'(in_ready), 32'd0);
    step(0, 0, 0, 32'h0, 0);
    chk("first_edge_in_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].h, vecs[i].t, vecs[i].f, vecs[i].ordy);
      chk($sformatf("v%0d_occ", i),       32'(occupancy), 32'(vecs[i].occ));
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].occ != 3'd0));
      chk($sformatf("v%0d_in_ready", i),  32'(in_ready),  32'(vecs[i].irdy));
      chk($sformatf("v%0d_pkt", i),       32'(pkt_count), 32'(vecs[i].pkt));
      chk($sformatf("v%0d_err", i),       32'(err),       32'(vecs[i].err));
      if (vecs[i].occ != 3'd0) begin
        chk($sformatf("v%0d_out_flit", i), out_flit,          vecs[i].of);
        chk($sformatf("v%0d_out_hdr", i),  32'(out_is_header), 32'(vecs[i].oh));
        chk($sformatf("v%0d_out_tail", i), 32'(out_is_tail),   32'(vecs[i].ot));
      end
    end

    // Reset mid-packet: asynchronous, outputs clear without a clock edge.
    step(1, 1, 0, 32'h300, 0);
    step(1, 0, 0, 32'h301, 0);
    step(1, 0, 0, 32'h302, 0);
    chk("midpkt_occ", 32'(occupancy), 32'd3);
    in_valid = 1'b0;
    #2 noc_rst = 1'b1;
    #1 chk_reset_vals("midrst");
    @(posedge noc_clk); #1;
    noc_rst = 1'b0;
    step(0, 0, 0, 32'h0, 0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_no_resume", 32'(out_valid), 32'd0);

    // Orphan data flit with no header.
    step(1, 0, 0, 32'h400, 0);
`ifdef NOC_INJ_FRAME_CHECK_EN
    chk("orphan_occ", 32'(occupancy), 32'd0);
    chk("orphan_err", 32'(err), 32'd1);
`else
    chk("orphan_occ", 32'(occupancy), 32'd1);
    chk("orphan_out_flit", out_flit, 32'h400);
    chk("orphan_err", 32'(err), 32'd0);
`endif
    step(0, 0, 0, 32'h0, 1);
    chk("orphan_drain_occ", 32'(occupancy), 32'd0);

    // Fresh header, data, duplicate header, tail.
    step(1, 1, 0, 32'h500, 0);
    step(1, 0, 0, 32'h501, 0);
    step(1, 1, 0, 32'h502, 0);
    step(1, 0, 1, 32'h503, 0);
`ifdef NOC_INJ_FRAME_CHECK_EN
    exp_q = '{32'h500, 32'h501, 32'h503};
    e_fr  = 2'b01;
`else
    exp_q = '{32'h500, 32'h501, 32'h502, 32'h503};
    e_fr  = 2'b00;
`endif
    chk("duphdr_occ", 32'(occupancy), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      chk($sformatf("duphdr_flit%0d", i), out_flit, exp_q[i]);
      step(0, 0, 0, 32'h0, 1);
    end
    chk("duphdr_empty", 32'(out_valid), 32'd0);
    chk("duphdr_pkt", 32'(pkt_count), 32'd1);
    chk("duphdr_err", 32'(err), 32'(e_fr));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
